// File: rtl/pwm_fade_bank_if.sv
// Write port of pwm_fade_bank: one target-duty write per asserted cycle.
// The controller drives through master; the PWM bank samples through slave.
interface pwm_fade_bank_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             wr_en;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_duty;
    logic             wr_fade;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_duty,
        output wr_fade
    );

    modport slave (
        input wr_en,
        input wr_ch,
        input wr_duty,
        input wr_fade
    );
endinterface

// File: rtl/pwm_fade_bank.sv
// Multi-channel PWM bank on one shared period counter.
// Each channel jumps or ramps its active duty toward a target at period boundaries.
module pwm_fade_bank #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 16,
    parameter int PERIOD     = 50_000,
    parameter int FADE_STEP  = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_fade_bank_if.slave      wr,
    output logic [CHANNELS-1:0] pwm,
    output logic [CHANNELS-1:0] busy,
    output logic                period_tick
);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PER     = CNT_W'(PERIOD);
    localparam logic [CNT_W:0]   STEP    = (CNT_W + 1)'(FADE_STEP);
    localparam logic             ON_LVL  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                run_q, run_d;
    logic                tick_q, tick_d;
    logic [CNT_W-1:0]    target_q [CHANNELS];
    logic [CNT_W-1:0]    target_d [CHANNELS];
    logic [CNT_W-1:0]    active_q [CHANNELS];
    logic [CNT_W-1:0]    active_d [CHANNELS];
    logic [CHANNELS-1:0] fade_q, fade_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] busy_q, busy_d;

    logic                boundary;
    logic                wr_hit;
    logic [31:0]         wr_sel;
    logic [CNT_W-1:0]    duty_clamped;

    // One fade step at CNT_W+1 bits: lands exactly on the target, never wraps.
    function automatic logic [CNT_W-1:0] ramp(
        input logic [CNT_W-1:0] act,
        input logic [CNT_W-1:0] tgt
    );
        logic [CNT_W:0] a;
        logic [CNT_W:0] t;
        logic [CNT_W:0] sum;
        a    = {1'b0, act};
        t    = {1'b0, tgt};
        sum  = a;
        ramp = act;
        if (a < t) begin
            sum  = a + STEP;
            ramp = (sum >= t) ? tgt : sum[CNT_W-1:0];
        end else if (a > t) begin
            sum  = a - STEP;
            ramp = ((a - t) <= STEP) ? tgt : sum[CNT_W-1:0];
        end
    endfunction

    always_comb begin
        boundary     = (cnt_q == LAST);
        run_d        = 1'b1;
        tick_d       = boundary;
        cnt_d        = cnt_q + 1'b1;
        // The first edge out of reset holds cnt at 0.
        if (!run_q || boundary) begin
            cnt_d = '0;
        end
        wr_sel       = 32'(wr.wr_ch);
        wr_hit       = wr.wr_en && (wr_sel < 32'(CHANNELS));
        duty_clamped = (wr.wr_duty > PER) ? PER : wr.wr_duty;
        fade_d       = fade_q;
        pwm_d        = pwm_q;
        busy_d       = busy_q;
        for (int i = 0; i < CHANNELS; i++) begin
            target_d[i] = target_q[i];
            active_d[i] = active_q[i];
            if (wr_hit && (wr_sel == 32'(i))) begin
                target_d[i] = duty_clamped;
                fade_d[i]   = wr.wr_fade;
            end
            if (boundary) begin
                active_d[i] = fade_q[i] ? ramp(active_q[i], target_q[i])
                                        : target_q[i];
            end
            pwm_d[i]  = (cnt_q < active_q[i]) ? ON_LVL : ~ON_LVL;
            busy_d[i] = (active_q[i] != target_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            run_q  <= 1'b0;
            tick_q <= 1'b0;
            fade_q <= '0;
            pwm_q  <= {CHANNELS{~ON_LVL}};
            busy_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            tick_q <= tick_d;
            fade_q <= fade_d;
            pwm_q  <= pwm_d;
            busy_q <= busy_d;
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= target_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm         = pwm_q;
    assign busy        = busy_q;
    assign period_tick = tick_q;
endmodule

// File: tb/tb_pwm_fade_bank.sv
// Bench for pwm_fade_bank: directed vector table, corner sequences, random writes.
// Three copies run in lockstep: active-low, active-high, and a 3-channel bank.
module tb_pwm_fade_bank;
    localparam int P = 10;
    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        t_en;
    logic [1:0]  t_ch;
    logic [15:0] t_duty;
    logic        t_fade;

    logic [3:0] pwm_a, busy_a, pwm_b, busy_b;
    logic [2:0] pwm_c, busy_c;
    logic       tick_a, tick_b, tick_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pwm_fade_bank_if #(.CHANNELS(4), .CNT_W(16)) ia ();
    pwm_fade_bank_if #(.CHANNELS(4), .CNT_W(16)) ib ();
    pwm_fade_bank_if #(.CHANNELS(3), .CNT_W(16)) ic ();

    assign ia.wr_en = t_en;
    assign ia.wr_ch = t_ch;
    assign ia.wr_duty = t_duty;
    assign ia.wr_fade = t_fade;
    assign ib.wr_en = t_en;
    assign ib.wr_ch = t_ch;
    assign ib.wr_duty = t_duty;
    assign ib.wr_fade = t_fade;
    assign ic.wr_en = t_en;
    assign ic.wr_ch = t_ch;
    assign ic.wr_duty = t_duty;
    assign ic.wr_fade = t_fade;

    pwm_fade_bank #(
        .CHANNELS(4), .CNT_W(16), .PERIOD(P),
        .FADE_STEP(S), .ACTIVE_LOW(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .wr(ia),
        .pwm(pwm_a), .busy(busy_a), .period_tick(tick_a)
    );

    pwm_fade_bank #(
        .CHANNELS(4), .CNT_W(16), .PERIOD(P),
        .FADE_STEP(S), .ACTIVE_LOW(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .wr(ib),
        .pwm(pwm_b), .busy(busy_b), .period_tick(tick_b)
    );

    pwm_fade_bank #(
        .CHANNELS(3), .CNT_W(16), .PERIOD(P),
        .FADE_STEP(S), .ACTIVE_LOW(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .wr(ic),
        .pwm(pwm_c), .busy(busy_c), .period_tick(tick_c)
    );

    // Reference model: integer duty bookkeeping per channel.
    int       m_tgt [4];
    int       m_act [4];
    bit       m_fd [4];
    int       m_cnt;
    bit       m_run;
    bit       m_wrap;
    bit [3:0] m_on;
    bit [3:0] m_busy;
    bit       m_tick;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        bit r, we, f, bnd;
        int ch, d;
        bit [3:0] ea, eb;
        r  = rst_n;
        we = t_en;
        ch = int'(t_ch);
        d  = int'(t_duty);
        f  = t_fade;
        @(posedge clk);
        if (!r) begin
            m_cnt  = 0;
            m_run  = 0;
            m_wrap = 0;
            m_on   = '0;
            m_busy = '0;
            m_tick = 0;
            for (int i = 0; i < 4; i++) begin
                m_tgt[i] = 0;
                m_act[i] = 0;
                m_fd[i]  = 0;
            end
        end else begin
            bnd = (m_cnt == P - 1);
            for (int i = 0; i < 4; i++) begin
                m_on[i]   = (m_cnt < m_act[i]);
                m_busy[i] = (m_act[i] != m_tgt[i]);
            end
            m_tick = bnd;
            if (bnd) begin
                for (int i = 0; i < 4; i++) begin
                    if (!m_fd[i])
                        m_act[i] = m_tgt[i];
                    else if (m_act[i] < m_tgt[i])
                        m_act[i] = (m_act[i] + S > m_tgt[i]) ? m_tgt[i] : m_act[i] + S;
                    else if (m_act[i] > m_tgt[i])
                        m_act[i] = (m_act[i] - S < m_tgt[i]) ? m_tgt[i] : m_act[i] - S;
                end
            end
            if (we) begin
                m_tgt[ch] = (d > P) ? P : d;
                m_fd[ch]  = f;
            end
            if (!m_run) m_run = 1;
            else m_cnt = bnd ? 0 : m_cnt + 1;
            m_wrap = bnd;
        end
        #1;
        ea = ~m_on;
        eb = m_on;
        chk("pwm", {21'd0, pwm_c, pwm_b, pwm_a}, {21'd0, ea[2:0], eb, ea});
        chk("busy", {21'd0, busy_c, busy_b, busy_a},
            {21'd0, m_busy[2:0], m_busy, m_busy});
        chk("tick", {29'd0, tick_c, tick_b, tick_a}, {29'd0, {3{m_tick}}});
    endtask

    task automatic do_write(input int ch, input int d, input bit f);
        t_en   = 1'b1;
        t_ch   = 2'(ch);
        t_duty = 16'(d);
        t_fade = f;
        step();
        t_en   = 1'b0;
    endtask

    task automatic run_to_wrap();
        int n = 0;
        while (!m_wrap && n < 4 * P) begin
            step();
            n++;
        end
    endtask

    // Counts on-level cycles per channel over one full period after a wrap.
    task automatic measure(output int ca [4], output int cb [4]);
        for (int i = 0; i < 4; i++) begin
            ca[i] = 0;
            cb[i] = 0;
        end
        for (int k = 0; k < P; k++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                if (pwm_a[i] == 1'b0) ca[i]++;
                if (pwm_b[i] == 1'b1) cb[i]++;
            end
        end
    endtask

    typedef struct {
        bit en;
        int ch;
        int duty;
        bit fade;
        int chk_ch;
        int exp_on;
    } vec_t;

    initial begin
        vec_t tbl [8];
        int ca [4];
        int cb [4];
        int n;
        bit seen;

        tbl[0] = '{1, 1, 4, 0, 1, 4};
        tbl[1] = '{1, 0, 10, 1, 0, 3};
        tbl[2] = '{0, 0, 0, 0, 0, 6};
        tbl[3] = '{0, 0, 0, 0, 0, 9};
        tbl[4] = '{0, 0, 0, 0, 0, 10};
        tbl[5] = '{0, 0, 0, 0, 0, 10};
        tbl[6] = '{1, 2, 65535, 0, 2, 10};
        tbl[7] = '{1, 2, 0, 0, 2, 0};

        rst_n  = 1'b0;
        t_en   = 1'b0;
        t_ch   = '0;
        t_duty = '0;
        t_fade = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        step();
        chk("rel_pwm_a", {28'd0, pwm_a}, 32'hf);
        chk("rel_pwm_b", {28'd0, pwm_b}, 32'h0);
        chk("rel_busy", {28'd0, busy_a}, 32'h0);
        chk("rel_tick", {31'd0, tick_a}, 32'h0);
        n = 1;
        seen = 1'b0;
        while (!seen && n < 3 * P) begin
            step();
            n++;
            seen = tick_a;
        end
        chk("first_tick_edge", n, 11);
        measure(ca, cb);
        chk("idle_on_a", ca[0] + ca[1] + ca[2] + ca[3], 0);
        chk("tick_interval", {31'd0, tick_a}, 32'h1);

        for (int r = 0; r < 8; r++) begin
            run_to_wrap();
            if (tbl[r].en) begin
                do_write(tbl[r].ch, tbl[r].duty, tbl[r].fade);
                run_to_wrap();
            end
            measure(ca, cb);
            chk($sformatf("tbl%0d_on_a", r), ca[tbl[r].chk_ch], tbl[r].exp_on);
            chk($sformatf("tbl%0d_on_b", r), cb[tbl[r].chk_ch], tbl[r].exp_on);
        end

        // Writing the current active value clears busy without a boundary.
        run_to_wrap();
        do_write(1, 7, 0);
        step();
        chk("busy_set", {31'd0, busy_a[1]}, 32'h1);
        do_write(1, 4, 0);
        step();
        chk("busy_clear", {31'd0, busy_a[1]}, 32'h0);

        // Write landing on the boundary edge takes effect a period later.
        run_to_wrap();
        repeat (P - 1) step();
        do_write(3, 5, 0);
        measure(ca, cb);
        chk("coll_old_duty", ca[3], 0);
        chk("coll_busy_a", {28'd0, busy_a}, 32'h8);
        chk("coll_busy_c", {29'd0, busy_c}, 32'h0);
        measure(ca, cb);
        chk("coll_new_duty", ca[3], 5);
        chk("coll_new_duty_b", cb[3], 5);

        // Reset in the middle of a 10->0 ramp.
        run_to_wrap();
        do_write(0, 0, 1);
        run_to_wrap();
        step();
        run_to_wrap();
        chk("midfade_busy", {31'd0, busy_a[0]}, 32'h1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst_pwm_a", {28'd0, pwm_a}, 32'hf);
        chk("rst_pwm_b", {28'd0, pwm_b}, 32'h0);
        chk("rst_busy", {28'd0, busy_a}, 32'h0);
        chk("rst_tick", {31'd0, tick_a}, 32'h0);
        run_to_wrap();
        measure(ca, cb);
        chk("rst_on_a", ca[0] + ca[1] + ca[2] + ca[3], 0);
        chk("rst_on_b", cb[0] + cb[1] + cb[2] + cb[3], 0);

        // Random writes and occasional resets against the model.
        for (int k = 0; k < 1500; k++) begin
            rst_n  = ($urandom_range(0, 299) != 0);
            t_en   = ($urandom_range(0, 3) == 0);
            t_ch   = 2'($urandom_range(0, 3));
            t_duty = ($urandom_range(0, 9) == 0) ? 16'hffff
                                                  : 16'($urandom_range(0, 12));
            t_fade = 1'($urandom_range(0, 1));
            step();
        end
        rst_n = 1'b1;
        t_en  = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
